// File: rtl/segment_swap_pkg.sv
// segment_swap_pkg: shared modes, states and default widths for the segment swap controller.
package segment_swap_pkg;
  localparam int IDX_W = 15;
  localparam int REP_W = 16;
  typedef enum logic [1:0] {IMMEDIATE = 2'd0, SYNC_WRAP = 2'd1, REPEAT = 2'd2} swap_mode_t;
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT_WRAP = 2'd1, WAIT_REP = 2'd2} swap_state_t;
endpackage

// File: rtl/idx_wrap_detect.sv
// idx_wrap_detect: flags the cycle where the read index steps from the last valid index back to 0.
module idx_wrap_detect #(
  parameter int IDX_W = segment_swap_pkg::IDX_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] idx,
  input  logic [IDX_W-1:0] cycle_cur,
  output logic             wrap
);
  import segment_swap_pkg::*;
  logic [IDX_W-1:0] prev_idx;
  logic             prev_valid;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      prev_idx   <= '0;
      prev_valid <= 1'b0;
    end else begin
      prev_idx   <= idx;
      prev_valid <= 1'b1;
    end
  assign wrap = prev_valid && prev_idx == cycle_cur && idx == '0;
endmodule

// File: rtl/segment_swap_ctrl.sv
// segment_swap_ctrl: schedules the double-buffer read segment select, swapping immediately,
// at the next index wrap, or after a programmed number of wraps.
module segment_swap_ctrl #(
  parameter int IDX_W = segment_swap_pkg::IDX_W,
  parameter int REP_W = segment_swap_pkg::REP_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_segment,
  input  logic [1:0]       req_mode,
  input  logic [REP_W-1:0] req_rep,
  input  logic             cancel,
  input  logic [IDX_W-1:0] idx,
  input  logic [IDX_W-1:0] cycle_0,
  input  logic [IDX_W-1:0] cycle_1,
  output logic             segment,
  output logic             swap_pulse,
  output logic             pending,
  output logic [REP_W-1:0] wrap_cnt
);
  import segment_swap_pkg::*;
  swap_state_t      state, state_n;
  logic             target, wrap, accept, is_sync, is_rep, hit, fire, imm;
  logic             segment_n, swap_n, pending_n, ready_n;
  logic [REP_W-1:0] rep, wrap_cnt_n, wrap_inc;
  idx_wrap_detect #(.IDX_W(IDX_W)) u_wrap (
    .clk      (clk),
    .rst_n    (rst_n),
    .idx      (idx),
    .cycle_cur(segment ? cycle_1 : cycle_0),
    .wrap     (wrap)
  );
  assign accept   = req_valid && req_ready;
  assign is_sync  = req_mode == SYNC_WRAP;
  assign is_rep   = req_mode == REPEAT;
  assign imm      = accept && !is_sync && !is_rep;
  // widened compare so a saturated counter never falsely matches
  assign hit      = ({1'b0, wrap_cnt} + 1'b1) == {1'b0, rep};
  assign wrap_inc = &wrap_cnt ? wrap_cnt : wrap_cnt + 1'b1;
  assign fire     = state != IDLE && !cancel && wrap && (state == WAIT_WRAP || hit);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state      <= IDLE;
      segment    <= 1'b0;
      swap_pulse <= 1'b0;
      pending    <= 1'b0;
      wrap_cnt   <= '0;
      req_ready  <= 1'b0;
      target     <= 1'b0;
      rep        <= '0;
    end else begin
      state      <= state_n;
      segment    <= segment_n;
      swap_pulse <= swap_n;
      pending    <= pending_n;
      wrap_cnt   <= wrap_cnt_n;
      req_ready  <= ready_n;
      target     <= accept ? req_segment : target;
      rep        <= accept ? req_rep : rep;
    end
  always_comb begin
    state_n = state;
    if (state == IDLE)
      state_n = !accept ? IDLE : (is_sync || (is_rep && req_rep == '0)) ? WAIT_WRAP : is_rep ? WAIT_REP : IDLE;
    else if (cancel || fire)
      state_n = IDLE;
  end
  always_comb begin
    segment_n  = imm ? req_segment : fire ? target : segment;
    swap_n     = segment_n != segment;
    wrap_cnt_n = ((accept && is_rep) || (state != IDLE && cancel)) ? '0 :
                 (state == WAIT_REP && wrap) ? wrap_inc : wrap_cnt;
    pending_n  = state_n != IDLE;
    ready_n    = state_n == IDLE;
  end
endmodule

// File: doc/segment_swap_ctrl.md
Name: segment_swap_ctrl

Overview:
- Schedules the read-segment select for one double-buffered BRAM channel (modulation or STM); instantiated once per channel.
- Drives the read-side SEGMENT that picks between the bank-0 and bank-1 BRAM outputs.
- Accepts host segment-change requests and applies each one immediately, at the next index wrap, or after a programmed number of wraps.
- Emits a one-cycle swap strobe so the sampling logic can resynchronise.

Parameters:
- IDX_W, 15, width of the read index and cycle registers.
- REP_W, 16, width of the repeat count.

Ports:
- CLK  in  1  system clock; same clock as BRAM port B.
- RST_N  in  1  asynchronous, active-low reset.
- REQ_VALID  in  1  host request valid.
- REQ_READY  out  1  block can accept a request.
- REQ_SEGMENT  in  1  target segment.
- REQ_MODE  in  2  0 = IMMEDIATE, 1 = SYNC_WRAP, 2 = REPEAT, 3 = reserved (treated as IMMEDIATE).
- REQ_REP  in  REP_W  wraps to wait in REPEAT mode.
- CANCEL  in  1  abandons a pending request.
- IDX  in  IDX_W  current read index issued to the BRAM.
- CYCLE_0  in  IDX_W  last valid index of segment 0.
- CYCLE_1  in  IDX_W  last valid index of segment 1.
- SEGMENT  out  1  read-segment select.
- SWAP_PULSE  out  1  one-cycle strobe on every SEGMENT change.
- PENDING  out  1  a request is waiting to be applied.
- WRAP_CNT  out  REP_W  wraps counted so far in REPEAT mode.

Behaviour:
- Reset values (async on RST_N low):
  - SEGMENT = 0, SWAP_PULSE = 0, PENDING = 0, WRAP_CNT = 0, REQ_READY = 0, state = IDLE.
  - The prev_idx register is invalidated.
- REQ_READY = 1 only in state IDLE (registered, not derived from REQ_VALID). A request is accepted on a cycle where REQ_VALID & REQ_READY.
- Wrap event (combinational):
  - Fires when prev_valid & (prev_idx == CYCLE_cur) & (IDX == 0).
  - CYCLE_cur = SEGMENT ? CYCLE_1 : CYCLE_0.
  - prev_idx <= IDX every cycle; prev_valid is set one cycle after reset release.
  - CYCLE_cur == 0 gives a wrap on every cycle where IDX stays 0.
- State machine (states IDLE, WAIT_WRAP, WAIT_REP):
  - IDLE, request accepted with mode IMMEDIATE or reserved:
    - If REQ_SEGMENT != SEGMENT: SEGMENT <= REQ_SEGMENT and SWAP_PULSE <= 1 on the next edge.
    - If REQ_SEGMENT == SEGMENT: no change and no pulse.
    - State stays IDLE. Latency: accept at edge t, new SEGMENT visible after edge t+1 (1 cycle).
  - IDLE, request accepted with mode SYNC_WRAP: latch the target, PENDING <= 1, go to WAIT_WRAP.
  - IDLE, request accepted with mode REPEAT:
    - Latch the target and REQ_REP, WRAP_CNT <= 0, PENDING <= 1, go to WAIT_REP.
    - REQ_REP == 0 behaves exactly as SYNC_WRAP.
  - WAIT_WRAP, on a wrap event: SEGMENT <= target, SWAP_PULSE <= 1 (only if the value changes), PENDING <= 0, go to IDLE. The swap happens on the same edge at which IDX == 0 is sampled.
  - WAIT_REP, on a wrap event:
    - WRAP_CNT <= WRAP_CNT + 1, saturating at all-ones.
    - When WRAP_CNT + 1 == latched REP: perform the swap as in WAIT_WRAP and go to IDLE.
- CANCEL:
  - In WAIT_WRAP or WAIT_REP: go to IDLE, PENDING <= 0, WRAP_CNT <= 0, no swap.
  - CANCEL has priority over a wrap event in the same cycle.
  - In IDLE, CANCEL is ignored.
- SWAP_PULSE is high for exactly one cycle and is cleared on every edge it is not set.
- New requests while PENDING are back-pressured by REQ_READY = 0 and are never dropped.
- CYCLE_0 and CYCLE_1 are sampled live, not latched. The host must not change CYCLE_cur while PENDING.
- IDX beyond CYCLE_cur: no wrap event is produced until IDX returns through CYCLE_cur → 0.
- Reset mid-wait: the pending request is lost and SEGMENT returns to 0.

Decomposition:
- Shared package segment_swap_pkg:
  - enum swap_mode_t {IMMEDIATE, SYNC_WRAP, REPEAT}.
  - enum swap_state_t {IDLE, WAIT_WRAP, WAIT_REP}.
  - Default localparams IDX_W = 15 and REP_W = 16.
- Sub-module idx_wrap_detect: holds prev_idx/prev_valid and produces the wrap event from IDX and CYCLE_cur.

Test Plan:
- Reset release, REQ IMMEDIATE seg 1 at cycle 5 → SEGMENT = 1 and SWAP_PULSE = 1 at cycle 6 only; REQ_READY stays 1.
- SEGMENT = 0, CYCLE_0 = 3, IDX counting 0..3 repeatedly; REQ SYNC_WRAP seg 1 issued at IDX = 1 → PENDING = 1 and REQ_READY = 0; SEGMENT = 1 and pulse on the edge after IDX = 0 is sampled.
- REQ REPEAT seg 1, REP = 3, CYCLE_0 = 7 → WRAP_CNT steps 1, 2; swap on the 3rd wrap; PENDING drops on that same edge.
- Pending SYNC_WRAP with CANCEL asserted in the same cycle as a wrap → no swap, SEGMENT unchanged, state IDLE, no pulse.
- REQ IMMEDIATE with target equal to the current SEGMENT → no pulse; REQ_READY still 1; also REQ_REP = 0 in REPEAT mode swaps at the first wrap.
- RST_N asserted while in WAIT_REP with WRAP_CNT = 2 → all outputs return to reset values immediately (asynchronous); after release, REQ_READY = 1 on the first edge.
